lifo_test: RTL and testbench



---
 rtl/lifo_test.sv | 173 +++++++++++++++++
 tb/tb_lifo_test.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/lifo_test.sv
// Self-checking LIFO test fixture: fills, overflows, drains and underflows a small
// stack, comparing every popped word, and reports progress and a pass/fail verdict.
module lifo_test #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int PATTERN = 'hA5
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_run,
  input  logic                     i_inject,
  output logic                     o_running,
  output logic                     o_passed,
  output logic [2:0]               o_err_state,
  output logic [2:0]               o_dbg_state,
  output logic [$clog2(DEPTH):0]   o_dbg_ptr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [WIDTH-1:0] PAT      = PATTERN[WIDTH-1:0];
  localparam logic [PW-1:0]    PTR_FULL = PW'(DEPTH);
  localparam logic [AW-1:0]    K_LAST   = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_OVER  = 3'd2,
    S_DRAIN = 3'd3,
    S_UNDER = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Handshake: i_run is a level request sampled in IDLE; o_running is high from the
  // cycle after acceptance until the verdict cycle, where o_passed becomes valid.

  state_t           state_q, state_d;
  logic [AW-1:0]    k_q, k_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             pass_q, pass_d;
  logic [2:0]       err_q, err_d;
  logic             running_q, running_d;
  logic             passed_q, passed_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic             push, pop, fail, full, empty;
  logic [WIDTH-1:0] push_data, top;

  function automatic logic [WIDTH-1:0] f_data(input logic [AW-1:0] k);
    return WIDTH'(k) ^ PAT;
  endfunction

  assign full  = (ptr_q == PTR_FULL);
  assign empty = (ptr_q == '0);
  assign top   = mem_q[AW'(ptr_q - 1'b1)];

  // Sequencer: next state, counter and stack requests.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = '0;
    case (state_q)
      S_IDLE: begin
        if (i_run) begin
          k_d     = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        push      = 1'b1;
        push_data = f_data(k_q);
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_OVER;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_OVER: begin
        push      = 1'b1;
        push_data = '1;
        state_d   = S_DRAIN;
      end
      S_DRAIN: begin
        pop = 1'b1;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_UNDER;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_UNDER: begin
        pop     = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!i_run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stack: a push when full or a pop when empty leaves ptr and mem untouched.
  always_comb begin
    ptr_d = ptr_q;
    mem_d = mem_q;
    if (push && !full) begin
      mem_d[ptr_q[AW-1:0]] = push_data;
      ptr_d                = ptr_q + 1'b1;
    end else if (pop && !empty) begin
      ptr_d = ptr_q - 1'b1;
    end
  end

  // Checks and verdict; the first failing state code is kept.
  always_comb begin
    fail   = 1'b0;
    pass_d = pass_q;
    err_d  = err_q;
    case (state_q)
      S_OVER:  fail = !full || (ptr_d != PTR_FULL);
      S_DRAIN: fail = ((top ^ {{(WIDTH-1){1'b0}}, i_inject}) != f_data(K_LAST - k_q));
      S_UNDER: fail = !empty || (ptr_d != '0);
      default: fail = 1'b0;
    endcase
    if (state_q == S_IDLE && i_run) begin
      pass_d = 1'b1;
      err_d  = '0;
    end else if (fail) begin
      pass_d = 1'b0;
      if (err_q == '0) err_d = state_q;
    end
    running_d = (state_d == S_FILL) || (state_d == S_OVER) ||
                (state_d == S_DRAIN) || (state_d == S_UNDER);
    passed_d  = (state_d == S_DONE) && pass_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      ptr_q     <= '0;
      pass_q    <= 1'b1;
      err_q     <= '0;
      running_q <= 1'b0;
      passed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      ptr_q     <= ptr_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      running_q <= running_d;
      passed_q  <= passed_d;
    end
  end

  // Storage needs no reset: only words below ptr are ever read.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  assign o_running   = running_q;
  assign o_passed    = passed_q;
  assign o_err_state = err_q;
  assign o_dbg_state = state_q;
  assign o_dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_lifo_test.sv
// Bench for lifo_test: default build plus a DEPTH=4 build, run verdicts scored
// against an expected queue of {run length, passed, err_state}.
module tb_lifo_test;
  localparam int D  = 16;
  localparam int D4 = 4;
  localparam int W  = 12;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, run, inject;
  logic       running, passed;
  logic [2:0] err, dbg_state;
  logic [4:0] dbg_ptr;

  logic       rst_b, run_b, inject_b;
  logic       running_b, passed_b;
  logic [2:0] err_b, dbg_state_b;
  logic [2:0] dbg_ptr_b;

  lifo_test dut_a (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_inject(inject),
    .o_running(running), .o_passed(passed), .o_err_state(err),
    .o_dbg_state(dbg_state), .o_dbg_ptr(dbg_ptr)
  );

  lifo_test #(.WIDTH(8), .DEPTH(D4)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_run(run_b), .i_inject(inject_b),
    .o_running(running_b), .o_passed(passed_b), .o_err_state(err_b),
    .o_dbg_state(dbg_state_b), .o_dbg_ptr(dbg_ptr_b)
  );

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_run(input int len, input logic pass, input logic [2:0] e);
    logic [7:0] l8;
    l8 = 8'(len);
    exp_q.push_back({l8, pass, e});
  endtask

  task automatic score(input string who, input int len, input logic p, input logic [2:0] e);
    logic [W-1:0] x;
    if (exp_q.size() == 0) begin
      check_eq({who, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    x = exp_q.pop_front();
    check_eq({who, "_run_len"}, 32'(len), 32'(x[11:4]));
    check_eq({who, "_passed"}, 32'(p), 32'(x[3]));
    check_eq({who, "_err_state"}, 32'(e), 32'(x[2:0]));
  endtask

  // driver: raise run on dut_a, optionally inject on the n-th DRAIN cycle, score verdict
  task automatic run_a(input int inj_drain);
    int len = 0;
    int drain = 0;
    bit seen = 0;
    bit done = 0;
    run = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      inject = 1'b0;
      if (running) begin
        seen = 1;
        len++;
      end else if (seen) begin
        done = 1;
      end
      if (dbg_state == 3'd2) check_eq("ptr_over", 32'(dbg_ptr), D);
      if (dbg_state == 3'd3) begin
        drain++;
        if (drain == 1) check_eq("ptr_after_over", 32'(dbg_ptr), D);
        if (drain == inj_drain) inject = 1'b1;
      end
      if (dbg_state == 3'd4) check_eq("ptr_under", 32'(dbg_ptr), 0);
    end
    check_eq("run_finished", 32'(done), 32'd1);
    check_eq("ptr_after_under", 32'(dbg_ptr), 0);
    score("a", len, passed, err);
  endtask

  task automatic run_b_once();
    int len = 0;
    bit seen = 0;
    bit done = 0;
    bit after_over = 0;
    run_b = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (running_b) begin
        seen = 1;
        len++;
      end else if (seen) begin
        done = 1;
      end
      if (after_over) begin
        check_eq("b_ptr_after_over", 32'(dbg_ptr_b), D4);
        after_over = 0;
      end
      if (dbg_state_b == 3'd2) begin
        check_eq("b_ptr_over", 32'(dbg_ptr_b), D4);
        after_over = 1;
      end
      if (dbg_state_b == 3'd4) check_eq("b_ptr_under", 32'(dbg_ptr_b), 0);
    end
    check_eq("b_run_finished", 32'(done), 32'd1);
    check_eq("b_ptr_after_under", 32'(dbg_ptr_b), 0);
    score("b", len, passed_b, err_b);
  endtask

  initial begin
    int fills;
    rst = 1'b1; run = 1'b0; inject = 1'b0;
    rst_b = 1'b1; run_b = 1'b0; inject_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rst_b = 1'b0;

    check_eq("rst_running", 32'(running), 0);
    check_eq("rst_passed", 32'(passed), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_ptr", 32'(dbg_ptr), 0);
    check_eq("rst_state", 32'(dbg_state), 0);

    // idle with run low
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check_eq("idle_running", 32'(running), 0);
      check_eq("idle_passed", 32'(passed), 0);
      check_eq("idle_err", 32'(err), 0);
    end

    // clean run, run held high afterwards
    expect_run(2 * D + 2, 1'b1, 3'd0);
    run_a(0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check_eq("hold_running", 32'(running), 0);
      check_eq("hold_passed", 32'(passed), 1);
    end

    // drop run for one cycle, then restart
    run = 1'b0;
    @(negedge clk);
    check_eq("drop_passed", 32'(passed), 0);
    check_eq("drop_running", 32'(running), 0);
    expect_run(2 * D + 2, 1'b1, 3'd0);
    run_a(0);

    // fault injected on the 5th DRAIN cycle, then a clean run
    run = 1'b0;
    @(negedge clk);
    expect_run(2 * D + 2, 1'b0, 3'd3);
    run_a(5);
    run = 1'b0;
    @(negedge clk);
    expect_run(2 * D + 2, 1'b1, 3'd0);
    run_a(0);

    // reset during the 7th FILL cycle
    run = 1'b0;
    @(negedge clk);
    run = 1'b1;
    fills = 0;
    for (int c = 0; c < 50 && fills < 7; c++) begin
      @(negedge clk);
      if (dbg_state == 3'd1) fills++;
    end
    check_eq("fill_reached", 32'(fills), 7);
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_running", 32'(running), 0);
    check_eq("abort_passed", 32'(passed), 0);
    check_eq("abort_ptr", 32'(dbg_ptr), 0);
    check_eq("abort_state", 32'(dbg_state), 0);
    expect_run(2 * D + 2, 1'b1, 3'd0);
    run_a(0);

    // DEPTH=4 build
    expect_run(2 * D4 + 2, 1'b1, 3'd0);
    run_b_once();

    check_eq("sb_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
